// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA datapath widths and the Montgomery FSM state encoding
package rsa_pkg;

    localparam int OPW   = 512;
    localparam int ADDW  = 514;
    localparam int ITERS = 512;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ITER,
        ST_ADD_B,
        ST_WAIT_B,
        ST_PAR,
        ST_ADD_M,
        ST_WAIT_M,
        ST_SHIFT,
        ST_SUB,
        ST_WAIT_S,
        ST_FIN
    } mont_state_e;

endpackage

// File: rtl/montgomery_if.sv
// rtl/montgomery_if.sv - request/result bundle between the exponentiation controller and the multiplier
interface montgomery_if;
    import rsa_pkg::*;

    logic           start;
    logic [OPW-1:0] in_a;
    logic [OPW-1:0] in_b;
    logic [OPW-1:0] in_m;
    logic [OPW-1:0] result;
    logic           done;

    modport master (output start, in_a, in_b, in_m, input result, done);
    modport slave  (input start, in_a, in_b, in_m, output result, done);
endinterface

// File: rtl/adder.sv
// rtl/adder.sv - multi-precision add/subtract unit; result and done register one cycle after start
module adder
    import rsa_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            subtract,
    input  logic            shift,
    input  logic [ADDW-1:0] in_a,
    input  logic [ADDW-1:0] in_b,
    output logic [ADDW:0]   result,
    output logic            done
);
    logic [ADDW:0] sum;
    logic [ADDW:0] result_d, result_q;
    logic          done_d, done_q;

    always_comb begin
        sum      = subtract ? ({1'b0, in_a} - {1'b0, in_b}) : ({1'b0, in_a} + {1'b0, in_b});
        result_d = result_q;
        done_d   = start;
        // The shifted form keeps the sign bit so a halved difference stays negative.
        if (start) result_d = shift ? {sum[ADDW], sum[ADDW:1]} : sum;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
endmodule

// File: rtl/montgomery.sv
// rtl/montgomery.sv - bit-serial Montgomery multiplier: A*B*2^-512 mod M via the shared adder
module montgomery
    import rsa_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    montgomery_if.slave  bus
);
    mont_state_e     state_d, state_q;
    logic [OPW-1:0]  a_d, a_q, b_d, b_q, m_d, m_q;
    logic [ADDW-1:0] c_d, c_q, t_d, t_q;
    logic [8:0]      i_d, i_q;
    logic            neg_d, neg_q;
    logic [OPW-1:0]  result_d, result_q;
    logic            done_d, done_q;

    logic            add_start, add_sub, add_done;
    logic [ADDW-1:0] add_in_a, add_in_b;
    logic [ADDW:0]   add_result;

    // Operand muxing follows the state that owns the adder this cycle.
    always_comb begin
        add_start = (state_q == ST_ADD_B) || (state_q == ST_ADD_M) || (state_q == ST_SUB);
        add_sub   = (state_q == ST_SUB);
        add_in_a  = (state_q == ST_SUB) ? c_q : t_q;
        add_in_b  = {2'b00, (state_q == ST_ADD_B) ? b_q : m_q};
    end

    adder u_adder (
        .clk      (clk),
        .resetn   (resetn),
        .start    (add_start),
        .subtract (add_sub),
        .shift    (1'b0),
        .in_a     (add_in_a),
        .in_b     (add_in_b),
        .result   (add_result),
        .done     (add_done)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        c_d      = c_q;
        t_d      = t_q;
        i_d      = i_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                a_d     = bus.in_a;
                b_d     = bus.in_b;
                m_d     = bus.in_m;
                c_d     = '0;
                i_d     = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                t_d     = c_q;
                state_d = a_q[i_q] ? ST_ADD_B : ST_PAR;
            end
            ST_ADD_B:  state_d = ST_WAIT_B;
            ST_WAIT_B: if (add_done) begin
                t_d     = add_result[ADDW-1:0];
                state_d = ST_PAR;
            end
            ST_PAR:    state_d = t_q[0] ? ST_ADD_M : ST_SHIFT;
            ST_ADD_M:  state_d = ST_WAIT_M;
            ST_WAIT_M: if (add_done) begin
                t_d     = add_result[ADDW-1:0];
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                c_d     = {1'b0, t_q[ADDW-1:1]};
                i_d     = i_q + 9'd1;
                state_d = (i_q == 9'(ITERS - 1)) ? ST_SUB : ST_ITER;
            end
            ST_SUB:    state_d = ST_WAIT_S;
            ST_WAIT_S: if (add_done) begin
                t_d     = add_result[ADDW-1:0];
                neg_d   = add_result[ADDW];
                state_d = ST_FIN;
            end
            ST_FIN: begin
                result_d = neg_q ? c_q[OPW-1:0] : t_q[OPW-1:0];
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            t_q      <= '0;
            i_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            c_q      <= c_d;
            t_q      <= t_d;
            i_q      <= i_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_montgomery.sv
// tb/tb_montgomery.sv - directed and random checks of montgomery against an arithmetic reference
module tb_montgomery;
    import rsa_pkg::*;

    localparam int LAT = 1;
    localparam int TIMEOUT = 8000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    montgomery_if bus ();
    montgomery dut (.clk(clk), .resetn(resetn), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [511:0] mers;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // (A*B mod M) then divided by two 512 times in the ring mod M.
    function automatic logic [511:0] ref_mont(input logic [511:0] a, input logic [511:0] b,
                                              input logic [511:0] m);
        logic [1023:0] p;
        logic [512:0]  x;
        p = {512'd0, a} * {512'd0, b};
        p = p % {512'd0, m};
        x = {1'b0, p[511:0]};
        for (int k = 0; k < 512; k++) x = x[0] ? ((x + {1'b0, m}) >> 1) : (x >> 1);
        return x[511:0];
    endfunction

    task automatic run_op(input string tag, input logic [511:0] a, input logic [511:0] b,
                          input logic [511:0] m, output logic [511:0] res, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_a  = a;
        bus.in_b  = b;
        bus.in_m  = m;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_a  = rnd512();
        bus.in_b  = rnd512();
        bus.in_m  = rnd512();
        lat = 0;
        while (bus.done !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, {511'd0, bus.done}, 512'd1);
        lat = lat + 1;
        res = bus.result;
        @(negedge clk);
        check({tag, "_done_width"}, {511'd0, bus.done}, 512'd0);
        check({tag, "_result_hold"}, bus.result, res);
    endtask

    logic [511:0] res, exp1, a, b, m;
    int lat, n, pulses;

    initial begin
        mers      = '1;
        bus.start = 1'b0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        bus.in_m  = '0;
        repeat (3) @(negedge clk);
        check("reset_result", bus.result, 512'd0);
        check("reset_done", {511'd0, bus.done}, 512'd0);
        resetn = 1'b1;

        run_op("small_1_1", 512'd1, 512'd1, 512'd7, res, lat);
        check("small_1_1", res, 512'd2);
        run_op("small_6_6", 512'd6, 512'd6, 512'd7, res, lat);
        check("small_6_6", res, 512'd2);

        run_op("mers_2_3", 512'd2, 512'd3, mers, res, lat);
        check("mers_2_3", res, 512'd6);
        run_op("mers_m1", mers - 512'd1, mers - 512'd1, mers, res, lat);
        check("mers_m1", res, 512'd1);

        run_op("zero_a", 512'd0, mers - 512'd1, mers, res, lat);
        check("zero_a", res, 512'd0);
        check("zero_latency", 512'(lat), 512'(1 + 3 * ITERS + (1 + LAT) + 1));

        // Busy rule: start held high with fresh operands throughout the run.
        exp1 = 512'd6;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_a  = 512'd2;
        bus.in_b  = 512'd3;
        bus.in_m  = mers;
        @(negedge clk);
        n = 0;
        while (bus.done !== 1'b1 && n < TIMEOUT) begin
            bus.in_a = rnd512();
            bus.in_b = rnd512();
            bus.in_m = rnd512() | 512'd1;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        pulses = (bus.done === 1'b1) ? 1 : 0;
        check("busy_result", bus.result, exp1);
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("busy_pulses", 512'(pulses), 512'd1);
        check("busy_result_after", bus.result, exp1);

        // Reset around iteration 200 of an all-zero-A run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_a  = 512'd0;
        bus.in_b  = 512'd5;
        bus.in_m  = mers;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (600) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset_done", {511'd0, bus.done}, 512'd0);
        check("midreset_result", bus.result, 512'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        run_op("post_reset", 512'd1, 512'd1, 512'd7, res, lat);
        check("post_reset", res, 512'd2);

        for (int r = 0; r < 20; r++) begin
            m = rnd512() | 512'd1;
            m[500] = 1'b1;
            a = rnd512() % m;
            b = rnd512() % m;
            run_op($sformatf("rand%0d", r), a, b, m, res, lat);
            check($sformatf("rand%0d", r), res, ref_mont(a, b, m));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
